ccr_branch_unit: RTL and testbench

- Condition-code register stage directly downstream of the 8-bit ALU.
- Captures the ALU's combinational Z/N/C/V outputs into the architectural CCR and feeds the CCR back to the ALU's CCR input.
- Resolves conditional jumps (JZ/JN/JC/JV) and clears the tested flag when a jump is taken.
- Keeps a small flag-save stack for interrupt entry (save) and RTI (restore), so nested interrupts preserve flags.

---
 rtl/cpu_pkg.sv | 35 +++
 rtl/flag_save_stack.sv | 87 ++++++++
 rtl/ccr_branch_unit.sv | 71 +++++++
 tb/tb_ccr_branch_unit.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: flag bit positions, jump-condition encoding and the CCR layout.
// Pure types and constants; no state.
package cpu_pkg;

  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_C = 2;
  localparam int FLAG_V = 3;

  typedef enum logic [1:0] {
    JZ = 2'b00,
    JN = 2'b01,
    JC = 2'b10,
    JV = 2'b11
  } jcond_e;

  typedef struct packed {
    logic v;
    logic c;
    logic n;
    logic z;
  } ccr_t;

  function automatic logic [1:0] cond_flag_idx(input jcond_e cond);
    logic [1:0] idx;
    case (cond)
      JZ:      idx = 2'(FLAG_Z);
      JN:      idx = 2'(FLAG_N);
      JC:      idx = 2'(FLAG_C);
      default: idx = 2'(FLAG_V);
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/flag_save_stack.sv
// LIFO of CCR snapshots for interrupt nesting; push/pop take effect on the next edge, pop data is
// combinational from the top entry. No backpressure: overflow/underflow are dropped and flagged sticky.
module flag_save_stack
  import cpu_pkg::*;
#(
  parameter int SAVE_DEPTH = 2,
  parameter int PTR_W      = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic push_i,
  input  logic pop_i,
  input  ccr_t push_dat_i,
  output ccr_t pop_dat_o,
  output logic pop_ok_o,
  output logic full_o,
  output logic err_o
);

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_PARTIAL,
    ST_FULL
  } stk_state_e;

  stk_state_e       state_q, state_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic             err_q, err_d;
  ccr_t             mem_q [SAVE_DEPTH];
  ccr_t             mem_d [SAVE_DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      ptr_q   <= '0;
      err_q   <= 1'b0;
      for (int i = 0; i < SAVE_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      err_q   <= err_d;
      mem_q   <= mem_d;
    end
  end

  always_comb begin
    ptr_d     = ptr_q;
    err_d     = err_q;
    mem_d     = mem_q;
    pop_ok_o  = 1'b0;
    pop_dat_o = '0;

    // Loops instead of direct indexing keep the pointer width independent of the array size.
    for (int i = 0; i < SAVE_DEPTH; i++) begin
      if (ptr_q == PTR_W'(i + 1)) pop_dat_o = mem_q[i];
    end

    if (en_i) begin
      if (pop_i) begin
        if (state_q != ST_EMPTY) begin
          pop_ok_o = 1'b1;
          ptr_d    = ptr_q - PTR_W'(1);
        end else begin
          err_d = 1'b1;
        end
      end else if (push_i) begin
        if (state_q != ST_FULL) begin
          for (int i = 0; i < SAVE_DEPTH; i++) begin
            if (ptr_q == PTR_W'(i)) mem_d[i] = push_dat_i;
          end
          ptr_d = ptr_q + PTR_W'(1);
        end else begin
          err_d = 1'b1;
        end
      end
    end

    if (ptr_d == '0)                      state_d = ST_EMPTY;
    else if (ptr_d == PTR_W'(SAVE_DEPTH)) state_d = ST_FULL;
    else                                  state_d = ST_PARTIAL;
  end

  assign full_o = (ptr_q == PTR_W'(SAVE_DEPTH));
  assign err_o  = err_q;

endmodule

// File: rtl/ccr_branch_unit.sv
// Condition-code register after the ALU: forwards fresh flags, resolves JZ/JN/JC/JV with zero
// latency, and saves/restores flags for interrupts. stall freezes all state; flush kills writes and jumps.
module ccr_branch_unit
  import cpu_pkg::*;
#(
  parameter int SAVE_DEPTH = 2,
  parameter int PTR_W      = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       stall,
  input  logic       flush,
  input  logic [3:0] flag_we,
  input  logic       alu_z,
  input  logic       alu_n,
  input  logic       alu_c,
  input  logic       alu_v,
  input  logic       jmp_valid,
  input  logic [1:0] jmp_cond,
  input  logic       int_save,
  input  logic       rti_restore,
  output logic [3:0] ccr,
  output logic       jmp_taken,
  output logic       save_full,
  output logic       save_err
);

  ccr_t       ccr_q, ccr_d;
  ccr_t       popped;
  logic       pop_ok;
  logic [3:0] alu_flags;
  logic [3:0] f_fwd;
  logic [3:0] upd;
  logic [1:0] cond_idx;

  assign alu_flags = {alu_v, alu_c, alu_n, alu_z};
  assign f_fwd     = flush ? ccr_q : ((flag_we & alu_flags) | (~flag_we & ccr_q));
  assign cond_idx  = cond_flag_idx(jcond_e'(jmp_cond));
  assign jmp_taken = jmp_valid & ~flush & f_fwd[cond_idx];

  always_comb begin
    upd = f_fwd;
    if (jmp_taken) upd[cond_idx] = 1'b0;
    // A restore overrides whatever the instruction in this stage wanted to write.
    ccr_d = pop_ok ? popped : ccr_t'(upd);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         ccr_q <= '0;
    else if (!stall) ccr_q <= ccr_d;
  end

  flag_save_stack #(
    .SAVE_DEPTH(SAVE_DEPTH),
    .PTR_W     (PTR_W)
  ) u_save_stack (
    .clk       (clk),
    .rst       (rst),
    .en_i      (~stall),
    .push_i    (int_save),
    .pop_i     (rti_restore),
    .push_dat_i(ccr_t'(f_fwd)),
    .pop_dat_o (popped),
    .pop_ok_o  (pop_ok),
    .full_o    (save_full),
    .err_o     (save_err)
  );

  assign ccr = ccr_q;

endmodule

// File: tb/tb_ccr_branch_unit.sv
// Directed bench for ccr_branch_unit: reset, forwarding, jumps, nested save/restore, stall and flush.
// Latency: checks sampled 1 time unit after each rising edge, or combinationally between edges.
// Backpressure: none; a watchdog ends the run if the sequence does not complete in time.
module tb_ccr_branch_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       stall;
    logic       flush;
    logic [3:0] flag_we;
    logic       alu_z, alu_n, alu_c, alu_v;
    logic       jmp_valid;
    logic [1:0] jmp_cond;
    logic       int_save;
    logic       rti_restore;
    logic [3:0] ccr;
    logic       jmp_taken;
    logic       save_full;
    logic       save_err;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    bit done     = 1'b0;

    always #5 clk = ~clk;

    ccr_branch_unit #(.SAVE_DEPTH(2), .PTR_W(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .flush      (flush),
        .flag_we    (flag_we),
        .alu_z      (alu_z),
        .alu_n      (alu_n),
        .alu_c      (alu_c),
        .alu_v      (alu_v),
        .jmp_valid  (jmp_valid),
        .jmp_cond   (jmp_cond),
        .int_save   (int_save),
        .rti_restore(rti_restore),
        .ccr        (ccr),
        .jmp_taken  (jmp_taken),
        .save_full  (save_full),
        .save_err   (save_err)
    );

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        stall       = 1'b0;
        flush       = 1'b0;
        flag_we     = 4'h0;
        {alu_v, alu_c, alu_n, alu_z} = 4'h0;
        jmp_valid   = 1'b0;
        jmp_cond    = 2'b00;
        int_save    = 1'b0;
        rti_restore = 1'b0;
    endtask

    task automatic set_alu(input logic [3:0] f);
        {alu_v, alu_c, alu_n, alu_z} = f;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_ccr(input logic [3:0] f);
        flag_we = 4'hF;
        set_alu(f);
        step();
        clr();
    endtask

    initial begin
        #100000;
        if (!done) begin
            $error("TIMEOUT: test sequence did not complete");
            $finish;
        end
    end

    initial begin
        rst = 1'b1;
        clr();
        repeat (2) step();
        chk("rst_ccr", ccr, 4'h0);
        chk("rst_full", save_full, 1'b0);
        chk("rst_err", save_err, 1'b0);
        chk("rst_jmp", jmp_taken, 1'b0);
        rst = 1'b0;
        step();

        flag_we = 4'hF; set_alu(4'b1010); rti_restore = 1'b1;
        step(); clr();
        chk("pop_empty_ccr", ccr, 4'hA);
        chk("pop_empty_err", save_err, 1'b1);

        int_save = 1'b1;
        step(); clr();
        chk("push1_ccr", ccr, 4'hA);
        chk("push1_full", save_full, 1'b0);

        #2 rst = 1'b1;
        #1;
        chk("arst_ccr", ccr, 4'h0);
        chk("arst_full", save_full, 1'b0);
        chk("arst_err", save_err, 1'b0);
        step();
        rst = 1'b0;
        step();

        flag_we = 4'b0001; alu_z = 1'b1; jmp_valid = 1'b1; jmp_cond = 2'b00;
        #1;
        chk("fwd_jz_taken", jmp_taken, 1'b1);
        step(); clr();
        chk("fwd_jz_ccr", ccr, 4'h0);

        write_ccr(4'b0100);
        chk("set_c", ccr, 4'h4);
        jmp_valid = 1'b1; jmp_cond = 2'b01;
        #1;
        chk("jn_not_taken", jmp_taken, 1'b0);
        step(); clr();
        chk("jn_ccr", ccr, 4'h4);

        jmp_valid = 1'b1; jmp_cond = 2'b10;
        #1;
        chk("jc_taken", jmp_taken, 1'b1);
        step(); clr();
        chk("jc_clear", ccr, 4'h0);

        write_ccr(4'b0011);
        int_save = 1'b1;
        step(); clr();
        chk("nest_push1_ccr", ccr, 4'h3);
        chk("nest_push1_full", save_full, 1'b0);
        int_save = 1'b1; flag_we = 4'hF; set_alu(4'b1100);
        step(); clr();
        chk("nest_push2_ccr", ccr, 4'hC);
        chk("nest_push2_full", save_full, 1'b1);
        int_save = 1'b1;
        step(); clr();
        chk("nest_push3_full", save_full, 1'b1);
        chk("nest_push3_err", save_err, 1'b1);
        chk("nest_push3_ccr", ccr, 4'hC);
        write_ccr(4'b0000);
        chk("nest_zero", ccr, 4'h0);
        rti_restore = 1'b1; flag_we = 4'hF; set_alu(4'hF); jmp_valid = 1'b1; jmp_cond = 2'b00;
        step(); clr();
        chk("nest_pop1_ccr", ccr, 4'hC);
        chk("nest_pop1_full", save_full, 1'b0);
        rti_restore = 1'b1;
        step(); clr();
        chk("nest_pop2_ccr", ccr, 4'h3);
        rti_restore = 1'b1;
        step(); clr();
        chk("nest_pop3_ccr", ccr, 4'h3);
        chk("nest_pop3_err", save_err, 1'b1);

        write_ccr(4'b0101);
        int_save = 1'b1;
        step(); clr();
        write_ccr(4'b1111);
        chk("sim_pre_ccr", ccr, 4'hF);
        int_save = 1'b1; rti_restore = 1'b1;
        step(); clr();
        chk("sim_ccr", ccr, 4'h5);
        chk("sim_full", save_full, 1'b0);
        int_save = 1'b1;
        step(); clr();
        chk("sim_ptr1_full", save_full, 1'b0);
        int_save = 1'b1;
        step(); clr();
        chk("sim_ptr2_full", save_full, 1'b1);

        stall = 1'b1; rti_restore = 1'b1; flag_we = 4'hF; set_alu(4'hF);
        jmp_valid = 1'b1; jmp_cond = 2'b11;
        #1;
        chk("stall_jv_taken", jmp_taken, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_ccr", ccr, 4'h5);
            chk("stall_full", save_full, 1'b1);
        end
        clr();

        write_ccr(4'b0001);
        flush = 1'b1; flag_we = 4'b0100; alu_c = 1'b1; jmp_valid = 1'b1; jmp_cond = 2'b10;
        #1;
        chk("flush_jc", jmp_taken, 1'b0);
        step();
        chk("flush_ccr", ccr, 4'h1);
        flush = 1'b0;
        #1;
        chk("noflush_jc", jmp_taken, 1'b1);
        step(); clr();
        chk("noflush_ccr", ccr, 4'h1);
        chk("err_sticky", save_err, 1'b1);

        done = 1'b1;
        if (n_fail != 0) $error("%0d of %0d checks failed", n_fail, n_checks);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
